freq_meter: RTL and testbench

Gated frequency counter: counts rising edges of an external signal over a fixed window of system-clock cycles and reports the count, which equals the frequency in Hz when the window is one second. It is the measuring counterpart to the board's clock dividers. It checks generated slow clocks and external inputs against the 27 MHz system clock, and feeds a display or debug register.

---
 rtl/freq_meter_pkg.sv | 14 +
 rtl/sig_edge_sync.sv | 39 +++
 rtl/freq_meter.sv | 106 ++++++++++
 tb/tb_freq_meter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and default constants for the gated frequency counter.
// FREQ_METER_SYNC_EN (see sig_edge_sync) selects the input synchronizer.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGate,
    StDone
  } fm_state_e;

  localparam int unsigned FM_GATE_1S = 27000000;
  localparam int unsigned FM_CNT_W   = 32;

endpackage

// File: rtl/sig_edge_sync.sv
// Optional two-flop synchronizer followed by a rising-edge detector.
// Define FREQ_METER_SYNC_EN for asynchronous inputs; otherwise SIG_IN must be CLK_IN-synchronous.
module sig_edge_sync (
  input  logic CLK_IN,
  input  logic rst,
  input  logic SIG_IN,
  output logic rise
);

  logic sync;
  logic prev_q;

`ifdef FREQ_METER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge CLK_IN) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], SIG_IN};
    end
  end

  assign sync = sync_q[1];
`else
  assign sync = SIG_IN;
`endif

  always_ff @(posedge CLK_IN) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sync;
    end
  end

  assign rise = sync & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts rises of SIG_IN over GATE_CYCLES clocks and reports the count.
// FREQ_METER_SYNC_EN enables the SIG_IN synchronizer inside sig_edge_sync.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = FM_GATE_1S,
  parameter int unsigned CNT_W       = FM_CNT_W
) (
  input  logic             CLK_IN,
  input  logic             rst,
  input  logic             SIG_IN,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             ovf
);

  localparam int unsigned          GateW    = $clog2(GATE_CYCLES);
  localparam logic [GateW-1:0]     GateLast = GateW'(GATE_CYCLES - 1);

  fm_state_e        state_q, state_d;
  logic [GateW-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] freq_q;
  logic             ovf_q;
  logic             valid_q;
  logic             rise;

  sig_edge_sync u_sig_edge_sync (
    .CLK_IN (CLK_IN),
    .rst    (rst),
    .SIG_IN (SIG_IN),
    .rise   (rise)
  );

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    unique case (state_q)
      StIdle: begin
        if (start || cont) begin
          state_d    = StGate;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end
      end
      StGate: begin
        gate_cnt_d = gate_cnt_q + GateW'(1);
        // Saturate rather than wrap so an overrange window still reads as full-scale.
        if (rise) begin
          if (&edge_cnt_q) begin
            sat_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
        end
        if (gate_cnt_q == GateLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d    = cont ? StGate : StIdle;
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK_IN) begin
    if (rst) begin
      state_q    <= StIdle;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      valid_q    <= (state_q == StDone);
      if (state_q == StDone) begin
        freq_q <= edge_cnt_q;
        ovf_q  <= sat_q;
      end
    end
  end

  assign busy  = (state_q == StGate) || (state_q == StDone);
  assign freq  = freq_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: two instances (CNT_W 8 and 4) share stimulus and are
// compared against a window-sum model built from the recorded SIG_IN history.
module tb_freq_meter;

  localparam int unsigned G = 100;
`ifdef FREQ_METER_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif
  localparam int HistN = 16384;

  logic       CLK_IN = 1'b0;
  logic       rst    = 1'b1;
  logic       SIG_IN = 1'b0;
  logic       start  = 1'b0;
  logic       cont   = 1'b1;
  logic       busy8, valid8, ovf8;
  logic [7:0] freq8;
  logic       busy4, valid4, ovf4;
  logic [3:0] freq4;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit sig_hist [HistN];
  int gen_mode   = 2;
  int gen_period = 10;
  int gen_phase  = 0;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) dut (
    .CLK_IN (CLK_IN), .rst (rst), .SIG_IN (SIG_IN), .start (start), .cont (cont),
    .busy (busy8), .freq (freq8), .valid (valid8), .ovf (ovf8)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
    .CLK_IN (CLK_IN), .rst (rst), .SIG_IN (SIG_IN), .start (start), .cont (cont),
    .busy (busy4), .freq (freq4), .valid (valid4), .ovf (ovf4)
  );

  always #5 CLK_IN = ~CLK_IN;

  // Value of SIG_IN seen at each edge; reset edges count as 0 because all input flops clear.
  always @(posedge CLK_IN) begin
    if (cyc < HistN) sig_hist[cyc[13:0]] <= rst ? 1'b0 : SIG_IN;
    cyc <= cyc + 1;
  end

  initial begin
    forever begin
      @(posedge CLK_IN);
      #1;
      if (gen_mode == 1) begin
        SIG_IN    = (gen_phase < gen_period / 2);
        gen_phase = (gen_phase + 1) % gen_period;
      end else if (gen_mode == 2) begin
        SIG_IN = 1'($urandom_range(0, 1));
      end
    end
  end

  // A rise of SIG_IN between edges k-1 and k is counted at edge k+Lat.
  function automatic int rise_at(input int e);
    int idx = e - Lat;
    if (idx < 1 || idx >= HistN) return 0;
    return (sig_hist[idx[13:0]] && !sig_hist[(idx - 1) & (HistN - 1)]) ? 1 : 0;
  endfunction

  function automatic int model_count(input int n0);
    int sum = 0;
    for (int e = n0 + 1; e <= n0 + int'(G); e++) sum += rise_at(e);
    return sum;
  endfunction

  function automatic int sat_to(input int raw, input int w);
    int mx = (1 << w) - 1;
    return (raw > mx) ? mx : raw;
  endfunction

  task automatic kick(output int n0);
    start = 1'b1;
    @(posedge CLK_IN);
    #1;
    start = 1'b0;
    n0 = cyc - 1;
  endtask

  // Runs one window that opened at edge n0; the current time is just after edge n0.
  task automatic measure(input int n0, input bit busy_after, input int drop_cont_at,
                         input int start_at, input int sig_at, input int exp_const,
                         input string name);
    int errs = 0;
    int raw;
    for (int i = 1; i <= int'(G); i++) begin
      @(posedge CLK_IN);
      #1;
      if (busy8 !== 1'b1 || valid8 !== 1'b0 || busy4 !== 1'b1 || valid4 !== 1'b0) errs++;
      start = (i == start_at);
      if (i == drop_cont_at) cont = 1'b0;
      if (i == sig_at) SIG_IN = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL %s_gate: busy/valid wrong in %0d gate cycles, required 0", name, errs);
    end
    @(posedge CLK_IN);
    #1;
    raw = model_count(n0);
    checks++;
    if (valid8 !== 1'b1 || valid4 !== 1'b1) begin
      failures++;
      $display("FAIL %s_valid: got %b/%b, required 1/1", name, valid8, valid4);
    end
    checks++;
    if (freq8 !== 8'(sat_to(raw, 8)) || ovf8 !== (raw > 255)) begin
      failures++;
      $display("FAIL %s_freq8: got %0d ovf %b, required %0d ovf %b", name, freq8, ovf8,
               sat_to(raw, 8), raw > 255);
    end
    checks++;
    if (freq4 !== 4'(sat_to(raw, 4)) || ovf4 !== (raw > 15)) begin
      failures++;
      $display("FAIL %s_freq4: got %0d ovf %b, required %0d ovf %b", name, freq4, ovf4,
               sat_to(raw, 4), raw > 15);
    end
    checks++;
    if (busy8 !== busy_after || busy4 !== busy_after) begin
      failures++;
      $display("FAIL %s_busy_after: got %b/%b, required %b", name, busy8, busy4, busy_after);
    end
    if (exp_const >= 0) begin
      checks++;
      if (freq8 !== 8'(exp_const)) begin
        failures++;
        $display("FAIL %s_spec_count: got %0d, required %0d", name, freq8, exp_const);
      end
    end
  endtask

  task automatic check_idle(input int n, input string name);
    int errs = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK_IN);
      #1;
      if (busy8 !== 1'b0 || valid8 !== 1'b0 || busy4 !== 1'b0 || valid4 !== 1'b0) errs++;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL %s: busy/valid high in %0d idle cycles, required 0", name, errs);
    end
  endtask

  task automatic test_reset();
    int n0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK_IN);
      #1;
      checks++;
      if (busy8 !== 1'b0 || busy4 !== 1'b0) begin
        failures++;
        $display("FAIL reset_busy: got %b/%b, required 0", busy8, busy4);
      end
      checks++;
      if (valid8 !== 1'b0 || valid4 !== 1'b0) begin
        failures++;
        $display("FAIL reset_valid: got %b/%b, required 0", valid8, valid4);
      end
      checks++;
      if (freq8 !== 8'd0 || freq4 !== 4'd0) begin
        failures++;
        $display("FAIL reset_freq: got %0d/%0d, required 0", freq8, freq4);
      end
      checks++;
      if (ovf8 !== 1'b0 || ovf4 !== 1'b0) begin
        failures++;
        $display("FAIL reset_ovf: got %b/%b, required 0", ovf8, ovf4);
      end
    end
    // SIG_IN held high out of reset is seen as a rise because prev clears.
    gen_mode = 0;
    SIG_IN   = 1'b1;
    cont     = 1'b0;
    @(posedge CLK_IN);
    #1;
    rst = 1'b0;
    kick(n0);
    measure(n0, 1'b0, 0, 0, 0, -1, "held_high");
    SIG_IN = 1'b0;
    check_idle(3, "held_high_idle");
  endtask

  task automatic test_single_shot();
    int n0;
    gen_mode   = 1;
    gen_period = 10;
    gen_phase  = 3;
    repeat (4) @(posedge CLK_IN);
    #1;
    kick(n0);
    measure(n0, 1'b0, 0, 0, 0, 10, "single_shot");
    check_idle(5, "single_shot_idle");
  endtask

  task automatic test_saturation();
    int n0;
    gen_mode   = 1;
    gen_period = 4;
    gen_phase  = 0;
    kick(n0);
    measure(n0, 1'b0, 0, 0, 0, 25, "saturate");
    gen_period = 10;
    gen_phase  = 0;
    kick(n0);
    measure(n0, 1'b0, 0, 0, 0, 10, "after_saturate");
  endtask

  task automatic test_continuous();
    int n0;
    gen_mode   = 1;
    gen_period = 20;
    gen_phase  = 0;
    cont       = 1'b1;
    @(posedge CLK_IN);
    #1;
    n0 = cyc - 1;
    measure(n0, 1'b1, 0, 0, 0, 5, "cont_w0");
    measure(n0 + int'(G) + 1, 1'b1, 0, 0, 0, 5, "cont_w1");
    measure(n0 + 2 * (int'(G) + 1), 1'b0, 50, 0, 0, 5, "cont_drop");
    check_idle(150, "cont_stopped");
  endtask

  task automatic test_start_ignored();
    int n0;
    gen_mode   = 1;
    gen_period = 10;
    kick(n0);
    measure(n0, 1'b0, 0, 30, 0, 10, "start_ignored");
    check_idle(130, "start_not_queued");
  endtask

  task automatic test_abort();
    int n0;
    // Reset during DONE: the completing window must not publish.
    kick(n0);
    repeat (G) @(posedge CLK_IN);
    #1;
    rst = 1'b1;
    @(posedge CLK_IN);
    #1;
    rst = 1'b0;
    checks++;
    if (valid8 !== 1'b0 || freq8 !== 8'd0 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL abort_done: valid %b freq %0d busy %b, required 0 0 0", valid8, freq8, busy8);
    end
    check_idle(110, "abort_done_idle");
    kick(n0);
    measure(n0, 1'b0, 0, 0, 0, 10, "pre_abort");
    kick(n0);
    repeat (50) @(posedge CLK_IN);
    #1;
    rst = 1'b1;
    @(posedge CLK_IN);
    #1;
    rst = 1'b0;
    checks++;
    if (valid8 !== 1'b0 || freq8 !== 8'd0 || ovf8 !== 1'b0 || busy8 !== 1'b0 ||
        freq4 !== 4'd0 || busy4 !== 1'b0) begin
      failures++;
      $display("FAIL abort_gate: valid %b freq %0d/%0d ovf %b busy %b/%b, required all 0",
               valid8, freq8, freq4, ovf8, busy8, busy4);
    end
    check_idle(150, "abort_gate_idle");
  endtask

  task automatic test_sync_latency();
    int n0;
    gen_mode = 0;
    SIG_IN   = 1'b0;
    repeat (5) @(posedge CLK_IN);
    #1;
    kick(n0);
    measure(n0, 1'b0, 0, 0, 98, (Lat == 0) ? 1 : 0, "late_rise");
    SIG_IN = 1'b0;
    check_idle(3, "late_rise_idle");
  endtask

  task automatic test_random();
    int n0;
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        gen_mode = 2;
      end else begin
        gen_mode   = 1;
        gen_period = $urandom_range(2, 40);
        gen_phase  = $urandom_range(0, gen_period - 1);
      end
      repeat ($urandom_range(1, 5)) @(posedge CLK_IN);
      #1;
      kick(n0);
      measure(n0, 1'b0, 0, $urandom_range(0, 99), 0, -1, "random");
    end
    gen_mode = 2;
    cont     = 1'b1;
    @(posedge CLK_IN);
    #1;
    n0 = cyc - 1;
    measure(n0, 1'b1, 0, 0, 0, -1, "random_cont0");
    measure(n0 + int'(G) + 1, 1'b0, $urandom_range(1, 99), 0, 0, -1, "random_cont1");
    check_idle(5, "random_cont_idle");
    gen_mode = 0;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_saturation();
    test_continuous();
    test_start_ignored();
    test_abort();
    test_sync_latency();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
